// File: rtl/alu_result_buffer.sv
// alu_result_buffer: a small circular FIFO between the ALU and its consumer.
// Each entry holds the ALU result, the opcode tag that produced it and the
// four ALU flags. The block also keeps a sticky overflow indicator and a
// 16-bit count of accepted results. Flow control is a valid/ready handshake
// on both sides. Outputs come straight from registered state, and there is
// no path from input to output within the same cycle.
module alu_result_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         ALUOut,
  input  logic [3:0]               ALUctl,
  input  logic                     carryout,
  input  logic                     zero,
  input  logic                     overflow,
  input  logic                     negative,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [3:0]               out_ctl,
  output logic [3:0]               out_flags,
  output logic                     sticky_ovf,
  input  logic                     clr_sticky,
  output logic [15:0]              op_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  // Entry layout, MSB first: {ctl[3:0], carryout, zero, overflow, negative, data}.
  localparam int EW = WIDTH + 8;
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   EMPTY_LVL = (AW+1)'(0);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);

  // Registered state.
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          sticky_q, sticky_d;
  logic [15:0]   op_count_q, op_count_d;
  logic [EW-1:0] mem_q [DEPTH];

  // Handshake qualifiers, all derived from registered occupancy.
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [EW-1:0] wr_entry_s;
  logic [EW-1:0] head_s;

  assign full_s     = (level_q == FULL_LVL);
  assign empty_s    = (level_q == EMPTY_LVL);
  // Input readiness never looks at out_ready, so a full buffer cannot
  // accept a new entry even when the head is being popped this cycle.
  assign push_s     = in_valid && !full_s;
  assign pop_s      = out_ready && !empty_s;
  assign wr_entry_s = {ALUctl, carryout, zero, overflow, negative, ALUOut};
  assign head_s     = mem_q[rd_ptr_q];

  // Compute next pointers, occupancy, sticky flag and push counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    sticky_d   = sticky_q;
    op_count_d = op_count_q;

    if (push_s) begin
      wr_ptr_d   = wr_ptr_q + PTR_ONE;
      op_count_d = op_count_q + 16'd1;
    end else begin
      wr_ptr_d   = wr_ptr_q;
      op_count_d = op_count_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // A new overflow result outranks a clear issued in the same cycle.
    if (push_s && overflow) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      level_q    <= EMPTY_LVL;
      sticky_q   <= 1'b0;
      op_count_q <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sticky_q   <= sticky_d;
      op_count_q <= op_count_d;
    end
  end

  // Entry storage: written on an accepted push, never cleared.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  assign in_ready   = !full_s;
  assign out_valid  = !empty_s;
  assign out_data   = head_s[WIDTH-1:0];
  assign out_flags  = head_s[WIDTH+3:WIDTH];
  assign out_ctl    = head_s[WIDTH+7:WIDTH+4];
  assign sticky_ovf = sticky_q;
  assign op_count   = op_count_q;
  assign level      = level_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer. The reference is an
// entry queue plus counters that are updated from the handshake rules.
module tb_alu_result_buffer;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  ALUOut;
  logic [3:0]        ALUctl;
  logic              carryout, zero, overflow, negative;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [3:0]        out_ctl;
  logic [3:0]        out_flags;
  logic              sticky_ovf;
  logic              clr_sticky;
  logic [15:0]       op_count;
  logic [2:0]        level;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [3:0]       c;
    logic [3:0]       f;
  } ent_t;

  ent_t        q[$];
  int unsigned m_cnt;
  bit          m_sticky;

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUOut(ALUOut), .ALUctl(ALUctl),
    .carryout(carryout), .zero(zero), .overflow(overflow), .negative(negative),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctl(out_ctl), .out_flags(out_flags),
    .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky),
    .op_count(op_count), .level(level)
  );

  always #5 clk = ~clk;

  // One clock: decide push/pop from the current inputs and model occupancy,
  // then advance the model after the edge.
  task automatic tick();
    bit   push, pop, ovf_push, clr;
    ent_t e;
    push     = in_valid && (q.size() < DEPTH);
    pop      = out_ready && (q.size() > 0);
    ovf_push = push && overflow;
    clr      = clr_sticky;
    e.d = ALUOut;
    e.c = ALUctl;
    e.f = {carryout, zero, overflow, negative};
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      m_cnt    = 0;
      m_sticky = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(e);
        m_cnt = (m_cnt + 1) & 32'h0000_FFFF;
      end
      if (ovf_push) m_sticky = 1;
      else if (clr) m_sticky = 0;
    end
  endtask

  task automatic set_in(input logic v, input logic [WIDTH-1:0] d,
                        input logic [3:0] c, input logic [3:0] f);
    in_valid = v;
    ALUOut   = d;
    ALUctl   = c;
    {carryout, zero, overflow, negative} = f;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (sticky_ovf !== 1'b0) begin bad++; $display("FAIL reset_sticky: got %b want 0", sticky_ovf); end
    total++; if (op_count !== 16'd0) begin bad++; $display("FAIL reset_op_count: got %0h want 0", op_count); end
  endtask

  task automatic test_first_push();
    out_ready = 1'b0;
    set_in(1'b1, 64'h198, 4'h2, 4'h0);
    tick();
    set_in(1'b0, 64'h0, 4'h0, 4'h0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", out_valid); end
    total++; if (out_data !== 64'h198) begin bad++; $display("FAIL first_data: got %0h want 198", out_data); end
    total++; if (out_ctl !== 4'h2) begin bad++; $display("FAIL first_ctl: got %0h want 2", out_ctl); end
    total++; if (out_flags !== 4'h0) begin bad++; $display("FAIL first_flags: got %0h want 0", out_flags); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL first_level: got %0d want 1", level); end
    total++; if (op_count !== 16'd1) begin bad++; $display("FAIL first_op_count: got %0d want 1", op_count); end
    // Head holds while downstream stalls.
    tick();
    total++; if (out_data !== 64'h198) begin bad++; $display("FAIL first_hold: got %0h want 198", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL first_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 64'(i), 4'(i), 4'(i));
      tick();
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL full_level: got %0d want 4", level); end
    set_in(1'b1, 64'd5, 4'd5, 4'd5);
    tick();
    set_in(1'b0, 64'd0, 4'd0, 4'd0);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL full_ignore_level: got %0d want 4", level); end
    total++; if (op_count !== 16'd5) begin bad++; $display("FAIL full_ignore_count: got %0d want 5", op_count); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 64'(i) || out_ctl !== 4'(i)) begin
        bad++;
        $display("FAIL drain_order: got v=%b d=%0h c=%0h want v=1 d=%0h c=%0h",
                 out_valid, out_data, out_ctl, i, i);
      end
      tick();
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp_q[$];
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, {$urandom, $urandom}, 4'($urandom), 4'($urandom));
      exp_q.push_back(ALUOut);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, {$urandom, $urandom}, 4'($urandom), 4'($urandom));
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
        bad++;
        $display("FAIL b2b_order[%0d]: got v=%b d=%0h want d=%0h", i, out_valid, out_data, exp_q[0]);
      end
      exp_q.push_back(ALUOut);
      void'(exp_q.pop_front());
      tick();
      total++; if (level !== 3'd2) begin bad++; $display("FAIL b2b_level[%0d]: got %0d want 2", i, level); end
    end
    set_in(1'b0, 64'd0, 4'd0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (out_data !== exp_q[0]) begin bad++; $display("FAIL b2b_tail[%0d]: got %0h want %0h", i, out_data, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_sticky();
    out_ready = 1'b1;
    set_in(1'b1, 64'hA, 4'h1, 4'b0010);
    tick();
    total++; if (sticky_ovf !== 1'b1) begin bad++; $display("FAIL sticky_set: got %b want 1", sticky_ovf); end
    clr_sticky = 1'b1;
    tick();
    total++; if (sticky_ovf !== 1'b1) begin bad++; $display("FAIL sticky_set_wins: got %b want 1", sticky_ovf); end
    set_in(1'b0, 64'h0, 4'h0, 4'h0);
    tick();
    clr_sticky = 1'b0;
    total++; if (sticky_ovf !== 1'b0) begin bad++; $display("FAIL sticky_clear: got %b want 0", sticky_ovf); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom), {$urandom, $urandom}, 4'($urandom), 4'($urandom));
      out_ready  = 1'($urandom);
      clr_sticky = ($urandom_range(0, 7) == 0);
      tick();
      total++;
      if (level !== 3'(q.size()) || out_valid !== (q.size() != 0) || in_ready !== (q.size() < DEPTH)) begin
        bad++;
        $display("FAIL rnd_occ[%0d]: got lvl=%0d ov=%b ir=%b want lvl=%0d", i, level, out_valid, in_ready, q.size());
      end
      total++;
      if (op_count !== 16'(m_cnt) || sticky_ovf !== m_sticky) begin
        bad++;
        $display("FAIL rnd_cnt[%0d]: got cnt=%0d st=%b want cnt=%0d st=%b", i, op_count, sticky_ovf, m_cnt, m_sticky);
      end
      if (q.size() != 0) begin
        total++;
        if (out_data !== q[0].d || out_ctl !== q[0].c || out_flags !== q[0].f) begin
          bad++;
          $display("FAIL rnd_head[%0d]: got %0h/%0h/%0h want %0h/%0h/%0h", i,
                   out_data, out_ctl, out_flags, q[0].d, q[0].c, q[0].f);
        end
      end
    end
    set_in(1'b0, 64'd0, 4'd0, 4'd0);
    clr_sticky = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic test_opcount_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    set_in(1'b1, 64'h1, 4'h0, 4'h0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    total++; if (op_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload: got %0h want ffff", op_count); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL wrap_level: got %0d want 1", level); end
    out_ready = 1'b0;
    tick();
    set_in(1'b0, 64'h0, 4'h0, 4'h0);
    total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %0h want 0", op_count); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 2 && q.size() != 0; k++) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 64'(i + 16), 4'h3, 4'b0010);
      tick();
    end
    total++; if (level !== 3'd3) begin bad++; $display("FAIL mid_preload: got %0d want 3", level); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (level !== 3'd0) begin bad++; $display("FAIL mid_level: got %0d want 0", level); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    total++; if (op_count !== 16'd0) begin bad++; $display("FAIL mid_op_count: got %0d want 0", op_count); end
    total++; if (sticky_ovf !== 1'b0) begin bad++; $display("FAIL mid_sticky: got %b want 0", sticky_ovf); end
    set_in(1'b0, 64'd0, 4'd0, 4'd0);
    tick();
    total++; if (level !== 3'd0) begin bad++; $display("FAIL mid_after: got %0d want 0", level); end
  endtask

  initial begin
    reset      = 1'b1;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    set_in(1'b0, 64'd0, 4'd0, 4'd0);
    test_reset();
    test_first_push();
    test_fill_drain();
    test_back_to_back();
    test_sticky();
    test_random();
    test_opcount_wrap();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter: WIDTH, 64, width of ALU result datapath.
REQ-002 Parameter: DEPTH, 4, number of buffer entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream ALU result is valid this cycle.
REQ-006 in_ready  output  1  buffer can accept an entry this cycle.
REQ-007 ALUOut  input  WIDTH  ALU result.
REQ-008 ALUctl  input  4  opcode that produced the result; stored as a tag.
REQ-009 carryout, zero, overflow, negative  input  1 each  ALU flags.
REQ-010 out_valid  output  1  head entry is valid.
REQ-011 out_ready  input  1  downstream accepts the head entry.
REQ-012 out_data  output  WIDTH  head entry result.
REQ-013 out_ctl  output  4  head entry opcode tag.
REQ-014 out_flags  output  4  head entry flags {carryout, zero, overflow, negative}, MSB first.
REQ-015 sticky_ovf  output  1  an accepted entry carried overflow=1 since the last clear.
REQ-016 clr_sticky  input  1  clears sticky_ovf.
REQ-017 op_count  output  16  number of accepted entries, modulo 2^16.
REQ-018 level  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 Push occurs on a cycle with in_valid && in_ready; pop occurs on a cycle with out_valid && out_ready.
REQ-020 The block shall be a circular FIFO with read and write pointers of $clog2(DEPTH) bits; each pointer wraps from DEPTH-1 to 0.
REQ-021 in_ready shall be !full, combinationally from registered state only; no dependence on out_ready, so there is no write-through when full.
REQ-022 out_valid shall be !empty; out_data, out_ctl and out_flags shall show the entry at the read pointer and hold stable while out_valid && !out_ready.
REQ-023 Latency: an entry pushed into an empty buffer shall appear with out_valid=1 on the cycle after the push; there is no combinational bypass.
REQ-024 Simultaneous push and pop with 0<level<DEPTH shall advance both pointers and leave level unchanged.
REQ-025 A push while full is impossible (in_ready=0), and in_valid is ignored; upstream holds its data.
REQ-026 A pop while empty is impossible (out_valid=0), and out_ready is ignored.
REQ-027 When empty, the outputs out_data, out_ctl and out_flags are don't-care; the bench shall check them only when out_valid=1.
REQ-028 On each push with overflow=1, sticky_ovf shall be 1 from the next cycle.
REQ-029 clr_sticky shall clear sticky_ovf on the next cycle; if clr_sticky and an overflow push occur in the same cycle, the set wins.
REQ-030 op_count shall increment by 1 per push and wrap from 0xFFFF to 0x0000.
REQ-031 level shall equal the number of pushes minus the number of pops since reset, in the range 0..DEPTH.

Reset
REQ-032 While reset=1 at a clock edge: pointers=0, level=0, out_valid=0, in_ready=1 after the edge, sticky_ovf=0, op_count=0.
REQ-033 Reset during a push or pop shall take priority; the in-flight entry is discarded and its push is not counted.
REQ-034 Storage array contents are not reset.

Verification
REQ-035 Scenario: reset, then push ALUOut=0x198, ALUctl=0x2, flags=0000 with out_ready=0 -> next cycle out_valid=1, out_data=0x198, out_ctl=0x2, level=1, op_count=1.
REQ-036 Scenario: out_ready=0, push 4 entries 0x1..0x4 -> in_ready=0 after the fourth push, level=4; a fifth in_valid is ignored; then drain with out_ready=1 -> 0x1, 0x2, 0x3, 0x4 in order, one per cycle, then out_valid=0.
REQ-037 Scenario: level=2, in_valid=1 and out_ready=1 together for 10 cycles -> level stays 2, the output order matches the push order, and the pointers wrap correctly.
REQ-038 Scenario: push with overflow=1 -> sticky_ovf=1; clr_sticky=1 in the same cycle as another overflow push -> sticky_ovf remains 1; clr_sticky alone -> sticky_ovf=0.
REQ-039 Scenario: preload op_count to 0xFFFF through 65535 pushes and pops, then one more push -> op_count=0x0000.
REQ-040 Scenario: reset asserted with level=3 and in_valid=1 -> next cycle level=0, out_valid=0, in_ready=1, op_count=0, sticky_ovf=0.
